keypad_event_encoder: RTL
=========================

// Module: keypad_event_encoder
// PURPOSE
//  Scans the 4x4 calculator keypad matrix, synchronises and debounces the row lines, and encodes each
//  accepted key press into exactly one single-cycle event pulse (num / OP / C / EQ) with its key code.
//  Sits between the board keypad pins and the calculator control FSM. It is the producer of the
//  event inputs that the FSM consumes.
// PARAMETERS
//  SCAN_DIV  1000  clk cycles each column stays driven during scanning (>=2)
//  DEB_CNT   20    consecutive stable clk cycles required to accept a press and to accept a release (>=1)
// PORTS
//  clk      in   1  system clock; single clock domain
//  resetn   in   1  reset, asynchronous, active-low
//  row_n    in   4  keypad rows, active-low, pulled up externally, asynchronous to clk
//  col_n    out  4  keypad column drive, one-cold (exactly one bit low)
//  num      out  1  1-cycle pulse: digit key accepted
//  OP       out  1  1-cycle pulse: operator key accepted
//  C        out  1  1-cycle pulse: clear key accepted
//  EQ       out  1  1-cycle pulse: equals key accepted
//  digit    out  4  last accepted digit 0-9; updates in the num pulse cycle and holds afterwards
//  op_code  out  2  last accepted operator: 00 +, 01 -, 10 *, 11 /; updates in the OP pulse cycle
//  key_busy out  1  high whenever the state is not SCAN
// BEHAVIOUR
//  Reset (async): state SCAN, col_idx 0, col_n=4'b1110, all pulses 0, digit 0, op_code 0, counters 0,
//   synchroniser flops 4'b1111. Reset in any state, including mid-debounce, emits no pulse.
//  Key map (row,col): r0: 1 2 3 +  | r1: 4 5 6 -  | r2: 7 8 9 *  | r3: C 0 = /
//  row_n passes through a 2-flop synchroniser to row_s. All decisions use row_s only.
//  FSM states:
//   SCAN: col_n = ~(1<<col_idx). A dwell counter counts 0..SCAN_DIV-1. On the last dwell cycle, row_s is
//    sampled. If exactly one row is low, latch cand_row/cand_col, clear deb counter, and go to DEBOUNCE
//    with the column frozen. Otherwise col_idx advances (3 wraps to 0). If 0 rows or >=2 rows are low,
//    the sample is ignored.
//   DEBOUNCE: column held. Each cycle where row_s equals the candidate pattern increments deb. Any
//    mismatch goes to SCAN, restarts the dwell and advances col_idx. When deb reaches DEB_CNT, go to EMIT.
//   EMIT (1 cycle): assert exactly one pulse from the key map, update digit or op_code, and go to
//    WAIT_RELEASE.
//   WAIT_RELEASE: column held. deb counts consecutive cycles with row_s==4'b1111. Any low row clears deb.
//    When deb reaches DEB_CNT, go to SCAN with dwell restarted and col_idx advanced.
//  Pulses are registered outputs, high only in the cycle the FSM occupies EMIT. Never two pulses in one
//   cycle, and never two pulses without an intervening full release (no auto-repeat).
//  Latency: the pulse occurs DEB_CNT+1 cycles after the SCAN sample cycle that detected the key, given a
//   clean press. The synchroniser adds 2 cycles ahead of that.
//  A second key pressed while one is held is ignored until all keys are released and the release is
//   debounced. If the held key changes during DEBOUNCE, it is treated as bounce and scanning resumes.
//  digit/op_code hold their values across C and EQ events. They change only on their own pulse.
//  Counter widths are $clog2(SCAN_DIV) and $clog2(DEB_CNT+1). Counters saturate and never wrap.
// STRUCTURE
//  Package calc_kbd_pkg: state encoding (SCAN, DEBOUNCE, EMIT, WAIT_RELEASE), op_code constants
//   (OP_ADD..OP_DIV), and the key-map constant table (row,col -> {class, value}).
//  Sub-module kbd_row_sync: 4-bit 2-flop synchroniser with async active-low reset to 1111.
//  The top holds the FSM, the dwell and debounce counters, and the key-map decode.
// TESTING (bench uses SCAN_DIV=4, DEB_CNT=3)
//  1 Reset: drop resetn mid-run -> col_n=4'b1110, num/OP/C/EQ=0, digit=0, op_code=0, key_busy=0 immediately.
//  2 Hold '5' (row_n[1] low whenever col_n[1]=0) for 60 cycles, then release -> exactly one num pulse,
//    digit=4'd5. No further pulse. key_busy falls DEB_CNT cycles after the release is seen on row_s.
//  3 Press '7' with the row toggling every 2 cycles for 12 cycles, then stable -> exactly one num pulse,
//    digit=7.
//  4 Sequence '=', 'C', '/', '-' with releases between -> one EQ pulse, then one C pulse, then OP with
//    op_code=2'b11, then OP with op_code=2'b01. digit is unchanged throughout.
//  5 Rows 0 and 2 held low together on col 1 -> no pulse, and col_n keeps rotating.
//  6 Assert resetn=0 during DEBOUNCE of '9' -> no pulse. On release of reset, state is SCAN and col_n=4'b1110.

Source files
------------

// File: rtl/calc_kbd_pkg.sv
// Shared types for the calculator keypad front end: FSM states, operator codes
// and the row/column key map.
package calc_kbd_pkg;

    typedef enum logic [1:0] {
        SCAN         = 2'd0,
        DEBOUNCE     = 2'd1,
        EMIT         = 2'd2,
        WAIT_RELEASE = 2'd3
    } kbd_state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        KC_NUM = 2'd0,
        KC_OP  = 2'd1,
        KC_CLR = 2'd2,
        KC_EQ  = 2'd3
    } key_class_t;

    typedef struct packed {
        key_class_t  cls;
        logic [3:0]  val;
    } key_entry_t;

    // Key map, indexed by {row, col}:
    //   r0: 1 2 3 +   r1: 4 5 6 -   r2: 7 8 9 *   r3: C 0 = /
    function automatic key_entry_t key_lookup(input logic [1:0] row, input logic [1:0] col);
        key_entry_t e;
        e = '{cls: KC_NUM, val: 4'd0};
        case ({row, col})
            4'h0: e = '{cls: KC_NUM, val: 4'd1};
            4'h1: e = '{cls: KC_NUM, val: 4'd2};
            4'h2: e = '{cls: KC_NUM, val: 4'd3};
            4'h3: e = '{cls: KC_OP,  val: {2'b00, OP_ADD}};
            4'h4: e = '{cls: KC_NUM, val: 4'd4};
            4'h5: e = '{cls: KC_NUM, val: 4'd5};
            4'h6: e = '{cls: KC_NUM, val: 4'd6};
            4'h7: e = '{cls: KC_OP,  val: {2'b00, OP_SUB}};
            4'h8: e = '{cls: KC_NUM, val: 4'd7};
            4'h9: e = '{cls: KC_NUM, val: 4'd8};
            4'hA: e = '{cls: KC_NUM, val: 4'd9};
            4'hB: e = '{cls: KC_OP,  val: {2'b00, OP_MUL}};
            4'hC: e = '{cls: KC_CLR, val: 4'd0};
            4'hD: e = '{cls: KC_NUM, val: 4'd0};
            4'hE: e = '{cls: KC_EQ,  val: 4'd0};
            4'hF: e = '{cls: KC_OP,  val: {2'b00, OP_DIV}};
        endcase
        return e;
    endfunction

    function automatic logic [1:0] cold_idx(input logic [3:0] r);
        logic [1:0] idx;
        case (r)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/kbd_row_sync.sv
// Two-flop synchroniser for the asynchronous keypad row lines; idles at
// all-released (1111) out of reset.
module kbd_row_sync (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] row_n,
    output logic [3:0] row_s
);

    logic [3:0] meta;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta  <= 4'hF;
            row_s <= 4'hF;
        end else begin
            meta  <= row_n;
            row_s <= meta;
        end
    end

endmodule

// File: rtl/keypad_event_encoder.sv
// 4x4 keypad scanner/debouncer producing one registered event pulse per accepted press.
//   state        | meaning
//   SCAN         | rotate one-cold column drive, sample rows on last dwell cycle
//   DEBOUNCE     | column frozen, count consecutive matches of the candidate row
//   EMIT         | one cycle, event pulse and digit/op_code update visible
//   WAIT_RELEASE | column frozen, count consecutive all-released cycles
module keypad_event_encoder
    import calc_kbd_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DEB_CNT  = 20
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic       num,
    output logic       OP,
    output logic       C,
    output logic       EQ,
    output logic [3:0] digit,
    output logic [1:0] op_code,
    output logic       key_busy
);

    localparam int DWELL_W = $clog2(SCAN_DIV);
    localparam int DEB_W   = $clog2(DEB_CNT + 1);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]   DEB_DONE   = DEB_W'(DEB_CNT);
    localparam logic [DEB_W-1:0]   DEB_MAX    = '1;

    kbd_state_t         state, state_nx;
    logic [DWELL_W-1:0] dwell, dwell_nx;
    logic [DEB_W-1:0]   deb, deb_nx, deb_inc;
    logic [1:0]         col_idx, col_nx;
    logic [1:0]         cand_row, cand_row_nx;
    logic [1:0]         cand_col, cand_col_nx;
    logic [3:0]         row_s;
    logic [3:0]         cand_pat;
    logic               emit_go;
    key_entry_t         key_cur;

    kbd_row_sync u_row_sync (
        .clk    (clk),
        .resetn (resetn),
        .row_n  (row_n),
        .row_s  (row_s)
    );

    assign col_n    = ~(4'b0001 << col_idx);
    assign cand_pat = ~(4'b0001 << cand_row);
    assign key_busy = (state != SCAN);
    assign deb_inc  = (deb == DEB_MAX) ? deb : deb + DEB_W'(1);
    assign key_cur  = key_lookup(cand_row, cand_col);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= SCAN;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        dwell_nx    = dwell;
        deb_nx      = deb;
        col_nx      = col_idx;
        cand_row_nx = cand_row;
        cand_col_nx = cand_col;
        case (state)
            SCAN: begin
                if (dwell == DWELL_LAST) begin
                    dwell_nx = '0;
                    // Zero or multiple low rows are ambiguous; only a single key is a candidate.
                    if ($onehot(~row_s)) begin
                        cand_row_nx = cold_idx(row_s);
                        cand_col_nx = col_idx;
                        deb_nx      = '0;
                        state_nx    = DEBOUNCE;
                    end else begin
                        col_nx = col_idx + 2'd1;
                    end
                end else begin
                    dwell_nx = dwell + DWELL_W'(1);
                end
            end
            DEBOUNCE: begin
                if (row_s == cand_pat) begin
                    deb_nx = deb_inc;
                    if (deb_inc == DEB_DONE) begin
                        deb_nx   = '0;
                        state_nx = EMIT;
                    end
                end else begin
                    deb_nx   = '0;
                    dwell_nx = '0;
                    col_nx   = col_idx + 2'd1;
                    state_nx = SCAN;
                end
            end
            EMIT: begin
                deb_nx   = '0;
                state_nx = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (row_s == 4'hF) begin
                    deb_nx = deb_inc;
                    if (deb_inc == DEB_DONE) begin
                        deb_nx   = '0;
                        dwell_nx = '0;
                        col_nx   = col_idx + 2'd1;
                        state_nx = SCAN;
                    end
                end else begin
                    deb_nx = '0;
                end
            end
            default: state_nx = SCAN;
        endcase
    end

    // Pulses are registered on entry to EMIT so they are high exactly while in EMIT.
    assign emit_go = (state == DEBOUNCE) && (state_nx == EMIT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dwell    <= '0;
            deb      <= '0;
            col_idx  <= 2'd0;
            cand_row <= 2'd0;
            cand_col <= 2'd0;
            num      <= 1'b0;
            OP       <= 1'b0;
            C        <= 1'b0;
            EQ       <= 1'b0;
            digit    <= 4'd0;
            op_code  <= OP_ADD;
        end else begin
            dwell    <= dwell_nx;
            deb      <= deb_nx;
            col_idx  <= col_nx;
            cand_row <= cand_row_nx;
            cand_col <= cand_col_nx;
            num      <= emit_go && (key_cur.cls == KC_NUM);
            OP       <= emit_go && (key_cur.cls == KC_OP);
            C        <= emit_go && (key_cur.cls == KC_CLR);
            EQ       <= emit_go && (key_cur.cls == KC_EQ);
            if (emit_go && (key_cur.cls == KC_NUM)) digit   <= key_cur.val;
            if (emit_go && (key_cur.cls == KC_OP))  op_code <= key_cur.val[1:0];
        end
    end

endmodule
